regfile_wr_arbiter: RTL

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for the register file: one holding slot per
// requester, round-robin between different indices, oldest-first on the same index.
module regfile_wr_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_reg,
   input  logic [63:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_reg,
   input  logic [63:0] req1_data,
   output logic        RegWrite,
   output logic [4:0]  WriteRegister,
   output logic [63:0] WriteData,
   output logic        busy
);

   logic        full0, full1;
   logic [4:0]  reg0, reg1;
   logic [63:0] data0, data1;
   logic        ptr;   // 1: requester 1 wins the next different-index contention
   logic        age;   // 1: slot 1 holds the older write
   logic        gnt0, gnt1, gnt_any;
   logic [4:0]  gnt_reg;
   logic [63:0] gnt_data;
   logic        acc0, acc1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (full0 && full1) begin
         if (reg0 == reg1) begin
            if (age) gnt1 = 1'b1;
            else     gnt0 = 1'b1;
         end else if (ptr) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else if (full0) begin
         gnt0 = 1'b1;
      end else if (full1) begin
         gnt1 = 1'b1;
      end
   end

   assign gnt_any  = gnt0 | gnt1;
   assign gnt_reg  = gnt1 ? reg1 : reg0;
   assign gnt_data = gnt1 ? data1 : data0;

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; ready depends only on slot/grant state, so a slot draining this cycle
   // can be refilled on the same edge.
   assign req0_ready = reset_n & (~full0 | gnt0);
   assign req1_ready = reset_n & (~full1 | gnt1);
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;

   assign busy = full0 | full1 | RegWrite;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full0         <= 1'b0;
         full1         <= 1'b0;
         reg0          <= 5'd0;
         reg1          <= 5'd0;
         data0         <= 64'd0;
         data1         <= 64'd0;
         ptr           <= 1'b0;
         age           <= 1'b0;
         RegWrite      <= 1'b0;
         WriteRegister <= 5'd0;
         WriteData     <= 64'd0;
      end else begin
         if (acc0) begin
            full0 <= 1'b1;
            reg0  <= req0_reg;
            data0 <= req0_data;
         end else if (gnt0) begin
            full0 <= 1'b0;
         end
         if (acc1) begin
            full1 <= 1'b1;
            reg1  <= req1_reg;
            data1 <= req1_data;
         end else if (gnt1) begin
            full1 <= 1'b0;
         end
         // A fill next to a surviving entry is younger; a simultaneous fill leaves slot 0 older.
         if (acc0 && full1 && !gnt1) age <= 1'b1;
         else if (acc1)              age <= 1'b0;
         if (full0 && full1) ptr <= gnt0;
         RegWrite <= gnt_any && (gnt_reg != 5'd31);
         if (gnt_any) begin
            WriteRegister <= gnt_reg;
            WriteData     <= gnt_data;
         end
      end
   end

endmodule
